// File: rtl/regfile_mp_sb_pkg.sv
// Shared widths and control levels for the multi-port register file and its scoreboard.
package regfile_mp_sb_pkg;

   localparam int unsigned REG_DW = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic RST_ENABLE   = 1'b1;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic READ_ENABLE  = 1'b1;
   localparam logic ISSUE_ENABLE = 1'b1;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the register file: write, read, issue-reserve ports and scoreboard view.
interface regfile_mp_sb_if
   import regfile_mp_sb_pkg::*;
#(
   parameter int unsigned DW = REG_DW,
   parameter int unsigned AW = REG_AW,
   parameter int unsigned NR = 2,
   parameter int unsigned NW = 1,
   parameter int unsigned NI = 1
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [NW-1:0]    we;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NR-1:0]    re;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic [NI-1:0]    iss_en;
   logic [NI*AW-1:0] iss_addr;
   logic [DEPTH-1:0] busy_vec;

   modport master (
      output we, waddr, wdata, re, raddr, iss_en, iss_addr,
      input  rdata, rbusy, busy_vec
   );

   modport slave (
      input  we, waddr, wdata, re, raddr, iss_en, iss_addr,
      output rdata, rbusy, busy_vec
   );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register pending-write flags: issue reserves, write completes, reserve beats complete.
module regfile_scoreboard
   import regfile_mp_sb_pkg::*;
#(
   parameter int unsigned AW = REG_AW,
   parameter int unsigned NW = 1,
   parameter int unsigned NI = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NI-1:0]        i_iss_en,
   input  logic [NI*AW-1:0]     i_iss_addr,
   input  logic [NW-1:0]        i_we,
   input  logic [NW*AW-1:0]     i_waddr,
   output logic [(1<<AW)-1:0]   o_busy_vec
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   // Clears first, sets after: a new producer in the same cycle supersedes the completing one.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int unsigned k = 0; k < NW; k++) begin
         if (i_we[k] == WRITE_ENABLE)
            w_busy_nxt[i_waddr[k*AW +: AW]] = 1'b0;
      end
      for (int unsigned i = 0; i < NI; i++) begin
         if (i_iss_en[i] == ISSUE_ENABLE)
            w_busy_nxt[i_iss_addr[i*AW +: AW]] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write forwarding and per-read-port stall from the scoreboard.
module regfile_mp_sb
   import regfile_mp_sb_pkg::*;
#(
   parameter int unsigned DW = REG_DW,
   parameter int unsigned AW = REG_AW,
   parameter int unsigned NR = 2,
   parameter int unsigned NW = 1,
   parameter int unsigned NI = 1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_mp_sb_if.slave bus
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0]    r_regs [DEPTH];
   logic [DEPTH-1:0] w_busy_vec;
   logic [NR*DW-1:0] w_rdata;
   logic [NR-1:0]    w_rbusy;

   regfile_scoreboard #(
      .AW (AW),
      .NW (NW),
      .NI (NI)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_iss_en   (bus.iss_en),
      .i_iss_addr (bus.iss_addr),
      .i_we       (bus.we),
      .i_waddr    (bus.waddr),
      .o_busy_vec (w_busy_vec)
   );

   // Ascending port order lets the highest-index write win via last non-blocking assignment.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         for (int unsigned a = 0; a < DEPTH; a++)
            r_regs[a] <= '0;
      end else begin
         for (int unsigned k = 0; k < NW; k++) begin
            if (bus.we[k] == WRITE_ENABLE && bus.waddr[k*AW +: AW] != '0)
               r_regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*DW +: DW];
         end
      end
   end

   always_comb begin
      logic [AW-1:0] w_ra;
      logic [DW-1:0] w_val;
      logic          w_hit;
      w_rdata = '0;
      w_rbusy = '0;
      for (int unsigned j = 0; j < NR; j++) begin
         w_ra  = bus.raddr[j*AW +: AW];
         w_val = '0;
         w_hit = 1'b0;
         if (rst != RST_ENABLE && bus.re[j] == READ_ENABLE && w_ra != '0) begin
            w_val = r_regs[w_ra];
            for (int unsigned k = 0; k < NW; k++) begin
               if (bus.we[k] == WRITE_ENABLE && bus.waddr[k*AW +: AW] == w_ra) begin
                  w_val = bus.wdata[k*DW +: DW];
                  w_hit = 1'b1;
               end
            end
            w_rbusy[j] = w_busy_vec[w_ra] & ~w_hit;
         end
         w_rdata[j*DW +: DW] = w_val;
      end
   end

   assign bus.rdata    = w_rdata;
   assign bus.rbusy    = w_rbusy;
   assign bus.busy_vec = w_busy_vec;

endmodule
